// File: rtl/rlbp_pkg.sv
// Shared types and constants for the RLBP Wishbone command master.
// Holds the command record, FSM state encoding and RLBP register offsets.
package rlbp_pkg;

  localparam logic [31:0] RLBP_BASE = 32'h3000_0000;

  localparam logic [7:0] CE_D1      = 8'd32;
  localparam logic [7:0] CE_D2      = 8'd36;
  localparam logic [7:0] CE_D3      = 8'd40;
  localparam logic [7:0] GPIO_START = 8'd44;
  localparam logic [7:0] LA_START   = 8'd48;
  localparam logic [7:0] DATA_IN    = 8'd52;
  localparam logic [7:0] DATA_SEL   = 8'd54;
  localparam logic [7:0] D          = 8'd58;
  localparam logic [7:0] DATA_OUT   = 8'd62;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  off;
    logic [3:0]  sel;
    logic [31:0] data;
  } rlbp_cmd_t;

  localparam int unsigned CMD_W = $bits(rlbp_cmd_t);

endpackage

// File: rtl/rlbp_cmd_fifo.sv
// Synchronous command queue; head is read from the registered read pointer.
// DEPTH must be a power of two and at least 2.
module rlbp_cmd_fifo
  import rlbp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  rlbp_cmd_t push_data,
  input  logic      pop,
  output rlbp_cmd_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rlbp_cmd_t         mem_q [DEPTH];
  rlbp_cmd_t         mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_en;
  logic              pop_en;

  // Push is refused while full even if a pop happens in the same cycle.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rlbp_wb_cmd_master.sv
// Wishbone classic initiator issuing queued register commands into the RLBP
// window and returning read data or a timeout error via a valid/ready port.
module rlbp_wb_cmd_master
  import rlbp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = RLBP_BASE,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_off,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  rlbp_cmd_t         push_cmd;
  rlbp_cmd_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign push_cmd = '{we: cmd_we, off: cmd_off, sel: cmd_sel, data: cmd_data};

  rlbp_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != IDLE);

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          adr_d   = {ADDR_BASE[31:8], head.off};
          we_d    = head.we;
          sel_d   = head.sel;
          dat_d   = head.data;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // Ack takes priority over a coincident timeout.
        if (wbm_ack_i) begin
          rsp_data_d = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d  = 1'b0;
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          state_d    = GAP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = 32'h0;
          rsp_err_d  = 1'b1;
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          state_d    = GAP;
        end
      end
      GAP: begin
        // One dead cycle swallows the slave's trailing ack.
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_rlbp_wb_cmd_master.sv
// Self-checking bench for rlbp_wb_cmd_master: table-driven single commands
// plus directed sequences for queueing, back-pressure, stale ack and reset.
module tb_rlbp_wb_cmd_master;
  import rlbp_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [7:0]  cmd_off;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  always #5 clk = ~clk;

  rlbp_wb_cmd_master #(
    .ADDR_BASE  (32'h3000_0000),
    .TIMEOUT    (TO),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_off   (cmd_off),
    .cmd_sel   (cmd_sel),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  // Slave model: DATA_SEL never acks, D acks for two cycles, others zero-wait.
  logic stretch;
  function automatic logic [31:0] slv_rdata(input logic [7:0] off);
    return (off == DATA_OUT) ? 32'h0000_0005 : {24'hC0FFEE, off};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      wbm_ack_i <= 1'b0;
      stretch   <= 1'b0;
    end else if (wbm_stb_o && !wbm_ack_i && wbm_adr_o[7:0] != DATA_SEL) begin
      wbm_ack_i <= 1'b1;
      stretch   <= (wbm_adr_o[7:0] == D);
    end else if (wbm_ack_i && stretch) begin
      wbm_ack_i <= 1'b1;
      stretch   <= 1'b0;
    end else begin
      wbm_ack_i <= 1'b0;
    end
  end

  assign wbm_dat_i = wbm_ack_i ? slv_rdata(wbm_adr_o[7:0]) : 32'hBAD0_BAD0;

  // Bus and response monitors.
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          cycles;
    int          unstable;
  } bus_rec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_rec_t;

  bus_rec_t bus_q[$];
  rsp_rec_t rsp_q[$];
  bus_rec_t cur;
  logic     prev_stb = 1'b0;
  int       cyc_stb_diff = 0;
  int       valid_cnt = 0;

  always @(negedge clk) begin
    if (wbm_cyc_o !== wbm_stb_o) cyc_stb_diff++;
    if (rsp_valid) valid_cnt++;
    if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_data, rsp_err});
    if (wbm_stb_o && !prev_stb) begin
      cur.adr      = wbm_adr_o;
      cur.we       = wbm_we_o;
      cur.sel      = wbm_sel_o;
      cur.dat      = wbm_dat_o;
      cur.cycles   = 1;
      cur.unstable = 0;
    end else if (wbm_stb_o) begin
      cur.cycles++;
      if ({wbm_adr_o, wbm_we_o, wbm_sel_o, wbm_dat_o} !== {cur.adr, cur.we, cur.sel, cur.dat})
        cur.unstable++;
    end else if (prev_stb) begin
      bus_q.push_back(cur);
    end
    prev_stb = wbm_stb_o;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; offers one command for one edge and reports acceptance.
  task automatic push(input logic we, input logic [7:0] off, input logic [3:0] sel,
                      input logic [31:0] data, output logic acc);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_off   = off;
    cmd_sel   = sel;
    cmd_data  = data;
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (rsp_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_count", 32'(rsp_q.size()), 32'(n));
  endtask

  task automatic chk_bus(input string tag, input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat, input int cycles);
    bus_rec_t r;
    if (bus_q.size() == 0) begin
      chk({tag, "_bus_present"}, 32'd0, 32'd1);
      return;
    end
    r = bus_q.pop_front();
    chk({tag, "_adr"}, r.adr, adr);
    chk({tag, "_we"}, 32'(r.we), 32'(we));
    chk({tag, "_sel"}, 32'(r.sel), 32'(sel));
    chk({tag, "_dat"}, r.dat, dat);
    chk({tag, "_stb_cycles"}, 32'(r.cycles), 32'(cycles));
    chk({tag, "_stable"}, 32'(r.unstable), 32'd0);
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] data, input logic err);
    rsp_rec_t r;
    if (rsp_q.size() == 0) begin
      chk({tag, "_rsp_present"}, 32'd0, 32'd1);
      return;
    end
    r = rsp_q.pop_front();
    chk({tag, "_rsp_data"}, r.data, data);
    chk({tag, "_rsp_err"}, 32'(r.err), 32'(err));
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_adr;
    int          exp_stb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vec[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic exp_acc;
    int   k;
    int   vbase;

    vec[0] = '{1'b1, CE_D1,      4'hF, 32'h0000_0001, 32'h3000_0020, 2,  32'h0,         1'b0};
    vec[1] = '{1'b0, DATA_OUT,   4'hF, 32'h0,         32'h3000_003E, 2,  32'h0000_0005, 1'b0};
    vec[2] = '{1'b1, CE_D2,      4'h3, 32'hA5A5_1234, 32'h3000_0024, 2,  32'h0,         1'b0};
    vec[3] = '{1'b0, DATA_SEL,   4'hF, 32'h0,         32'h3000_0036, 16, 32'h0,         1'b1};
    vec[4] = '{1'b0, GPIO_START, 4'h1, 32'h0,         32'h3000_002C, 2,  32'hC0FF_EE2C, 1'b0};
    vec[5] = '{1'b1, D,          4'hF, 32'h0000_00FF, 32'h3000_003A, 2,  32'h0,         1'b0};
    vec[6] = '{1'b0, CE_D3,      4'hF, 32'h0,         32'h3000_0028, 2,  32'hC0FF_EE28, 1'b0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_off   = '0;
    cmd_sel   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_bus", {31'd0, wbm_cyc_o | wbm_stb_o | wbm_we_o | (|wbm_sel_o) | (|wbm_adr_o) | (|wbm_dat_o)}, 32'd0);
    chk("reset_rsp", {31'd0, rsp_valid | rsp_err | (|rsp_data)}, 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    sync();

    // Single commands, one at a time.
    for (int i = 0; i < 7; i++) begin
      push(vec[i].we, vec[i].off, vec[i].sel, vec[i].data, acc);
      chk($sformatf("v%0d_accept", i), 32'(acc), 32'd1);
      wait_rsp(1, 100);
      chk_bus($sformatf("v%0d", i), vec[i].exp_adr, vec[i].we, vec[i].sel, vec[i].data, vec[i].exp_stb);
      chk_rsp($sformatf("v%0d", i), vec[i].exp_rdata, vec[i].exp_err);
      sync();
      sync();
    end

    // Pop to rsp_valid latency with a zero-wait slave: visible on the 5th negedge.
    push(1'b1, LA_START, 4'hF, 32'h1, acc);
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("latency_negedges", 32'(k), 32'd5);
    wait_rsp(1, 50);
    void'(rsp_q.pop_front());
    void'(bus_q.pop_front());
    sync();
    sync();

    // Queued: timeout then normal, double ack write then read.
    push(1'b0, DATA_SEL, 4'hF, 32'h0, acc);
    push(1'b1, D,        4'hF, 32'h0000_0077, acc);
    push(1'b0, DATA_OUT, 4'hF, 32'h0, acc);
    push(1'b0, CE_D1,    4'hF, 32'h0, acc);
    chk("q_busy", 32'(busy), 32'd1);
    wait_rsp(4, 300);
    chk_bus("q0", 32'h3000_0036, 1'b0, 4'hF, 32'h0, TO);
    chk_bus("q1", 32'h3000_003A, 1'b1, 4'hF, 32'h0000_0077, 2);
    chk_bus("q2", 32'h3000_003E, 1'b0, 4'hF, 32'h0, 2);
    chk_bus("q3", 32'h3000_0020, 1'b0, 4'hF, 32'h0, 2);
    chk_rsp("q0", 32'h0, 1'b1);
    chk_rsp("q1", 32'h0, 1'b0);
    chk_rsp("q2", 32'h0000_0005, 1'b0);
    chk_rsp("q3", 32'hC0FF_EE20, 1'b0);
    sync();
    sync();

    // Back-pressure: 1 in flight + 4 queued, 6th push refused.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(1'b0, 8'(32 + 4 * i), 4'hF, 32'h0, acc);
      exp_acc = (i < 5);
      chk($sformatf("bp_accept%0d", i), 32'(acc), 32'(exp_acc));
    end
    repeat (5) sync();
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_full", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    wait_rsp(5, 300);
    repeat (20) sync();
    chk("bp_total_rsp", 32'(rsp_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk_rsp($sformatf("bp%0d", i), {24'hC0FFEE, 8'(32 + 4 * i)}, 1'b0);
    end
    bus_q.delete();
    rsp_q.delete();

    // Reset while a non-acked read is in REQ with another queued.
    push(1'b0, DATA_SEL, 4'hF, 32'h0, acc);
    push(1'b0, CE_D1, 4'hF, 32'h0, acc);
    k = 0;
    while (!wbm_stb_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_req", 32'(wbm_stb_o), 32'd1);
    repeat (3) @(negedge clk);
    vbase = valid_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    repeat (40) sync();
    chk("rst_no_valid", 32'(valid_cnt - vbase), 32'd0);
    chk("rst_no_rsp", 32'(rsp_q.size()), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("cyc_stb_agree", 32'(cyc_stb_diff), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
